uart_mem_loader: RTL and testbench

UART_MEM_LOADER -- requirements
Module: uart_mem_loader

---
 rtl/uart_mem_loader.sv | 251 +++++++++++++++++++++++++
 tb/tb_uart_mem_loader.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_mem_loader.sv
// UART boot loader: receives a 16-bit little-endian word count, then that many
// little-endian 32-bit words over 8N1 serial, and writes them to a memory load port.
module uart_mem_loader #(
    parameter int unsigned CLKS_PER_BIT   = 434,
    parameter int unsigned TIMEOUT_CYCLES = 1048576,
    parameter int unsigned MAX_WORDS      = 4096
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        RXD,
    output logic        WR,
    output logic [11:0] WRADDR,
    output logic [31:0] WRDATA,
    output logic        LOAD_DONE,
    output logic        CPU_RESETn,
    output logic        ERR
);

    localparam int unsigned BIT_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned HALF  = CLKS_PER_BIT / 2;
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
    typedef enum logic [1:0] {HDR_LO, HDR_HI, DATA, DONE} ld_state_e;

    // ---------------- synchronizer ----------------
    logic rxd_meta_q, rxd_sync_q, rxd_prev_q;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            rxd_meta_q <= 1'b1;
            rxd_sync_q <= 1'b1;
            rxd_prev_q <= 1'b1;
        end else begin
            rxd_meta_q <= RXD;
            rxd_sync_q <= rxd_meta_q;
            rxd_prev_q <= rxd_sync_q;
        end
    end

    // ---------------- receiver ----------------
    rx_state_e        rx_state_q, rx_state_d;
    logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       byte_q, byte_d;
    logic             byte_vld_q, byte_vld_d;
    logic             frm_err_q, frm_err_d;
    logic             half_hit_c, bit_hit_c;

    assign half_hit_c = (bit_cnt_q == BIT_W'(HALF - 1));
    assign bit_hit_c  = (bit_cnt_q == BIT_W'(CLKS_PER_BIT - 1));

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            rx_state_q <= RX_IDLE;
            bit_cnt_q  <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            byte_q     <= '0;
            byte_vld_q <= 1'b0;
            frm_err_q  <= 1'b0;
        end else begin
            rx_state_q <= rx_state_d;
            bit_cnt_q  <= bit_cnt_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            byte_q     <= byte_d;
            byte_vld_q <= byte_vld_d;
            frm_err_q  <= frm_err_d;
        end
    end

    always_comb begin
        rx_state_d = rx_state_q;
        bit_cnt_d  = bit_cnt_q + BIT_W'(1);
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        byte_d     = byte_q;
        byte_vld_d = 1'b0;
        frm_err_d  = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                bit_cnt_d = '0;
                if (rxd_prev_q && !rxd_sync_q) begin
                    rx_state_d = RX_START;
                end
            end
            RX_START: begin
                // A start bit that is high again at its midpoint was a glitch.
                if (half_hit_c) begin
                    bit_cnt_d  = '0;
                    bit_idx_d  = '0;
                    rx_state_d = rxd_sync_q ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (bit_hit_c) begin
                    bit_cnt_d = '0;
                    shift_d   = {rxd_sync_q, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        rx_state_d = RX_STOP;
                    end
                end
            end
            default: begin
                if (bit_hit_c) begin
                    bit_cnt_d  = '0;
                    rx_state_d = RX_IDLE;
                    if (rxd_sync_q) begin
                        byte_vld_d = 1'b1;
                        byte_d     = shift_q;
                    end else begin
                        frm_err_d = 1'b1;
                    end
                end
            end
        endcase
    end

    // ---------------- loader ----------------
    ld_state_e        state_q, state_d;
    logic [15:0]      count_q, count_d;
    logic [15:0]      idx_q, idx_d;
    logic [1:0]       lane_q, lane_d;
    logic [23:0]      buf_q, buf_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             wr_q, wr_d;
    logic [11:0]      wraddr_q, wraddr_d;
    logic [31:0]      wrdata_q, wrdata_d;
    logic             err_q, err_d;
    logic             done_q, done_d;
    logic             cpu_rst_n_q, cpu_rst_n_d;
    logic [15:0]      hdr_c;
    logic             tmo_hit_c;

    assign hdr_c     = {byte_q, count_q[7:0]};
    assign tmo_hit_c = (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q     <= HDR_LO;
            count_q     <= '0;
            idx_q       <= '0;
            lane_q      <= '0;
            buf_q       <= '0;
            tmo_q       <= '0;
            wr_q        <= 1'b0;
            wraddr_q    <= '0;
            wrdata_q    <= '0;
            err_q       <= 1'b0;
            done_q      <= 1'b0;
            cpu_rst_n_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            idx_q       <= idx_d;
            lane_q      <= lane_d;
            buf_q       <= buf_d;
            tmo_q       <= tmo_d;
            wr_q        <= wr_d;
            wraddr_q    <= wraddr_d;
            wrdata_q    <= wrdata_d;
            err_q       <= err_d;
            done_q      <= done_d;
            cpu_rst_n_q <= cpu_rst_n_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        idx_d    = idx_q;
        lane_d   = lane_q;
        buf_d    = buf_q;
        tmo_d    = tmo_q + TMO_W'(1);
        wr_d     = 1'b0;
        wraddr_d = wraddr_q;
        wrdata_d = wrdata_q;
        err_d    = err_q;
        case (state_q)
            HDR_LO: begin
                tmo_d = '0;
                if (byte_vld_q) begin
                    count_d[7:0] = byte_q;
                    state_d      = HDR_HI;
                end
            end
            HDR_HI: begin
                // A received byte wins over a timeout expiring in the same cycle.
                if (byte_vld_q) begin
                    tmo_d   = '0;
                    count_d = hdr_c;
                    if (hdr_c == 16'd0) begin
                        state_d = DONE;
                    end else if (32'(hdr_c) > MAX_WORDS) begin
                        err_d   = 1'b1;
                        state_d = HDR_LO;
                    end else begin
                        err_d   = 1'b0;
                        idx_d   = '0;
                        lane_d  = '0;
                        buf_d   = '0;
                        state_d = DATA;
                    end
                end else if (tmo_hit_c) begin
                    err_d   = 1'b1;
                    state_d = HDR_LO;
                end
            end
            DATA: begin
                if (wr_q && (idx_q == count_q)) begin
                    state_d = DONE;
                end else if (byte_vld_q) begin
                    tmo_d  = '0;
                    lane_d = lane_q + 2'd1;
                    case (lane_q)
                        2'd0:    buf_d[7:0]   = byte_q;
                        2'd1:    buf_d[15:8]  = byte_q;
                        2'd2:    buf_d[23:16] = byte_q;
                        default: begin
                            wr_d     = 1'b1;
                            wraddr_d = idx_q[11:0];
                            wrdata_d = {byte_q, buf_q};
                            idx_d    = idx_q + 16'd1;
                        end
                    endcase
                end else if (tmo_hit_c) begin
                    err_d   = 1'b1;
                    state_d = HDR_LO;
                end
            end
            default: tmo_d = '0;
        endcase
        if (frm_err_q && (state_q != DONE)) begin
            err_d   = 1'b1;
            state_d = HDR_LO;
        end
        done_d      = (state_d == DONE);
        cpu_rst_n_d = (state_d == DONE);
    end

    assign WR         = wr_q;
    assign WRADDR     = wraddr_q;
    assign WRDATA     = wrdata_q;
    assign LOAD_DONE  = done_q;
    assign CPU_RESETn = cpu_rst_n_q;
    assign ERR        = err_q;

endmodule

// File: tb/tb_uart_mem_loader.sv
// Randomized bench for uart_mem_loader with a byte-level protocol model and scoreboard.
module tb_uart_mem_loader;

    localparam int unsigned CPB = 4;
    localparam int unsigned TMO = 200;

    logic        HCLK    = 1'b0;
    logic        HRESETn = 1'b0;
    logic        RXD     = 1'b1;
    logic        WR;
    logic [11:0] WRADDR;
    logic [31:0] WRDATA;
    logic        LOAD_DONE;
    logic        CPU_RESETn;
    logic        ERR;

    uart_mem_loader #(
        .CLKS_PER_BIT  (CPB),
        .TIMEOUT_CYCLES(TMO),
        .MAX_WORDS     (4096)
    ) dut (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .RXD       (RXD),
        .WR        (WR),
        .WRADDR    (WRADDR),
        .WRDATA    (WRDATA),
        .LOAD_DONE (LOAD_DONE),
        .CPU_RESETn(CPU_RESETn),
        .ERR       (ERR)
    );

    always #5 HCLK = ~HCLK;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [11:0] a;
        logic [31:0] d;
    } wr_t;

    wr_t exp_q[$];
    wr_t got_q[$];

    // Protocol model: phase 0 = expect count low, 1 = count high, 2 = data, 3 = done.
    int          m_phase;
    int unsigned m_count, m_idx, m_lane;
    logic [31:0] m_word;
    bit          m_err, m_done;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void m_reset();
        m_phase = 0; m_count = 0; m_idx = 0; m_lane = 0; m_word = '0;
        m_err = 1'b0; m_done = 1'b0;
        exp_q.delete();
    endfunction

    function automatic void m_byte(input logic [7:0] b);
        wr_t w;
        case (m_phase)
            0: begin m_count = 32'(b); m_phase = 1; end
            1: begin
                m_count = m_count + 256 * 32'(b);
                if (m_count == 0) begin
                    m_phase = 3; m_done = 1'b1;
                end else if (m_count > 4096) begin
                    m_err = 1'b1; m_phase = 0;
                end else begin
                    m_err = 1'b0; m_phase = 2; m_idx = 0; m_lane = 0; m_word = '0;
                end
            end
            2: begin
                m_word = m_word | (32'(b) << (8 * m_lane));
                m_lane++;
                if (m_lane == 4) begin
                    w.a = 12'(m_idx);
                    w.d = m_word;
                    exp_q.push_back(w);
                    m_idx++; m_lane = 0; m_word = '0;
                    if (m_idx == m_count) begin
                        m_phase = 3; m_done = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    endfunction

    function automatic void m_abort();
        if (m_phase != 3) begin
            m_err = 1'b1; m_phase = 0;
        end
    endfunction

    function automatic void m_timeout();
        if (m_phase == 1 || m_phase == 2) begin
            m_err = 1'b1; m_phase = 0;
        end
    endfunction

    // Scoreboard: every write must be expected, and the bus holds between writes.
    logic [11:0] last_a = '0;
    logic [31:0] last_d = '0;
    initial begin
        wr_t e;
        forever begin
            @(negedge HCLK);
            if (!HRESETn) begin
                last_a = '0; last_d = '0;
            end else if (WR) begin
                e.a = WRADDR; e.d = WRDATA;
                got_q.push_back(e);
                if (exp_q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL unexpected_wr: got addr %h data %h, required no write", WRADDR, WRDATA);
                end else begin
                    e = exp_q.pop_front();
                    check("wr_addr", 32'(WRADDR), 32'(e.a));
                    check("wr_data", WRDATA, e.d);
                    last_a = e.a; last_d = e.d;
                end
            end else begin
                check("hold_addr", 32'(WRADDR), 32'(last_a));
                check("hold_data", WRDATA, last_d);
            end
        end
    end

    task automatic drive_bit(input logic v);
        @(negedge HCLK);
        RXD = v;
        repeat (CPB - 1) @(negedge HCLK);
    endtask

    task automatic send_frame(input logic [7:0] b, input bit stop_ok);
        if (stop_ok) m_byte(b);
        else         m_abort();
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop_ok);
        @(negedge HCLK);
        RXD = 1'b1;
        repeat ($urandom_range(8, 30)) @(negedge HCLK);
    endtask

    task automatic sb(input logic [7:0] b);
        send_frame(b, 1'b1);
    endtask

    task automatic glitch();
        @(negedge HCLK);
        RXD = 1'b0;
        @(negedge HCLK);
        RXD = 1'b1;
        repeat (3 * CPB) @(negedge HCLK);
    endtask

    task automatic silence();
        m_timeout();
        repeat (TMO + 50) @(negedge HCLK);
    endtask

    task automatic checkpoint(input string tag);
        check({tag, "_err"}, 32'(ERR), 32'(m_err));
        check({tag, "_done"}, 32'(LOAD_DONE), 32'(m_done));
        check({tag, "_cpu_resetn"}, 32'(CPU_RESETn), 32'(m_done));
    endtask

    task automatic do_reset();
        check("pending_writes", 32'(exp_q.size()), 32'd0);
        @(negedge HCLK);
        #2;
        HRESETn = 1'b0;
        RXD     = 1'b1;
        m_reset();
        #1;
        check("rst_wr", 32'(WR), 32'd0);
        check("rst_wraddr", 32'(WRADDR), 32'd0);
        check("rst_wrdata", WRDATA, 32'd0);
        check("rst_done", 32'(LOAD_DONE), 32'd0);
        check("rst_cpu_resetn", 32'(CPU_RESETn), 32'd0);
        check("rst_err", 32'(ERR), 32'd0);
        repeat (3) @(negedge HCLK);
        HRESETn = 1'b1;
        got_q.delete();
    endtask

    task automatic load_one(input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2, input logic [7:0] b3);
        sb(8'h01); sb(8'h00); sb(b0); sb(b1); sb(b2); sb(b3);
    endtask

    initial begin
        logic [7:0]  stream[$];
        int unsigned cnt, r, ev;
        m_reset();
        repeat (3) @(negedge HCLK);
        check("init_wr", 32'(WR), 32'd0);
        check("init_done", 32'(LOAD_DONE), 32'd0);
        check("init_cpu_resetn", 32'(CPU_RESETn), 32'd0);
        HRESETn = 1'b1;
        @(negedge HCLK);

        // Two-word image, then trailing bytes that must be ignored.
        sb(8'h02); sb(8'h00);
        sb(8'h78); sb(8'h56); sb(8'h34); sb(8'h12);
        sb(8'hEF); sb(8'hBE); sb(8'hAD); sb(8'hDE);
        checkpoint("two_words");
        check("two_words_n", 32'(got_q.size()), 32'd2);
        if (got_q.size() == 2) begin
            check("w0_addr", 32'(got_q[0].a), 32'd0);
            check("w0_data", got_q[0].d, 32'h12345678);
            check("w1_addr", 32'(got_q[1].a), 32'd1);
            check("w1_data", got_q[1].d, 32'hDEADBEEF);
        end
        check("lit_done", 32'(LOAD_DONE), 32'd1);
        check("lit_cpu_resetn", 32'(CPU_RESETn), 32'd1);
        sb(8'h01); sb(8'h00); sb(8'h11); sb(8'h22); sb(8'h33); sb(8'h44);
        check("after_done_no_wr", 32'(got_q.size()), 32'd2);

        // Zero-length image.
        do_reset();
        sb(8'h00); sb(8'h00);
        checkpoint("zero_len");
        check("zero_len_done", 32'(LOAD_DONE), 32'd1);
        check("zero_len_n", 32'(got_q.size()), 32'd0);

        // Oversized header, then a valid one-word image clears ERR.
        do_reset();
        sb(8'h01); sb(8'h10);
        checkpoint("oversize");
        check("oversize_err", 32'(ERR), 32'd1);
        load_one(8'hAA, 8'hBB, 8'hCC, 8'hDD);
        checkpoint("after_oversize");
        check("after_oversize_err", 32'(ERR), 32'd0);
        check("after_oversize_n", 32'(got_q.size()), 32'd1);
        if (got_q.size() == 1) check("after_oversize_data", got_q[0].d, 32'hDDCCBBAA);

        // Maximum legal count is accepted; silence then times out.
        do_reset();
        sb(8'h00); sb(8'h10);
        check("max_count_err", 32'(ERR), 32'd0);
        sb(8'h01);
        silence();
        checkpoint("max_count_timeout");

        // Partial word then silence: timeout, then a fresh header works.
        do_reset();
        sb(8'h01); sb(8'h00); sb(8'h11); sb(8'h22);
        silence();
        checkpoint("timeout");
        check("timeout_err", 32'(ERR), 32'd1);
        check("timeout_n", 32'(got_q.size()), 32'd0);
        load_one(8'h01, 8'h02, 8'h03, 8'h04);
        checkpoint("after_timeout");
        if (got_q.size() == 1) check("after_timeout_data", got_q[0].d, 32'h04030201);

        // Framing error mid-word.
        do_reset();
        sb(8'h01); sb(8'h00); sb(8'h11);
        send_frame(8'h55, 1'b0);
        checkpoint("framing");
        check("framing_err", 32'(ERR), 32'd1);
        load_one(8'h10, 8'h20, 8'h30, 8'h40);
        checkpoint("after_framing");

        // Reset mid-word and mid-frame, glitch rejection.
        do_reset();
        sb(8'h01); sb(8'h00); sb(8'hAA); sb(8'hBB);
        do_reset();
        drive_bit(1'b0); drive_bit(1'b1); drive_bit(1'b0); drive_bit(1'b1);
        do_reset();
        glitch();
        load_one(8'h5A, 8'hC3, 8'h0F, 8'hF0);
        checkpoint("after_resets");
        check("after_resets_n", 32'(got_q.size()), 32'd1);
        if (got_q.size() == 1) begin
            check("after_resets_addr", 32'(got_q[0].a), 32'd0);
            check("after_resets_data", got_q[0].d, 32'hF00FC35A);
        end

        // Randomized images with injected faults.
        for (int it = 0; it < 18; it++) begin
            do_reset();
            stream.delete();
            r = $urandom_range(0, 9);
            if (r == 0)      cnt = 0;
            else if (r == 1) cnt = $urandom_range(4097, 65535);
            else             cnt = $urandom_range(1, 4);
            stream.push_back(8'(cnt)); stream.push_back(8'(cnt >> 8));
            if (cnt > 4096) begin
                cnt = $urandom_range(1, 3);
                stream.push_back(8'(cnt)); stream.push_back(8'h00);
            end
            for (int k = 0; k < int'(4 * cnt + 2); k++) stream.push_back(8'($urandom));
            foreach (stream[k]) begin
                ev = $urandom_range(0, 99);
                if (ev < 3)       send_frame(8'($urandom), 1'b0);
                else if (ev < 7)  glitch();
                else if (ev < 9)  silence();
                else if (ev < 11) do_reset();
                sb(stream[k]);
                checkpoint("rnd");
            end
        end
        do_reset();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
